sdc_dq_ctrl: RTL and testbench

- Sequencing stage directly upstream of the DQ pad wrapper.
- Drives the per-bit output data (sdc_dq_o) and tristate enables (sdc_dq_t), and captures returning pad data (sdc_dq_i) for the controller core.
- Turns single write/read burst commands from the command scheduler into cycle-exact write launch and CAS-latency-aligned read capture, with bus turnaround.

---
 rtl/sdc_dq_pkg.sv | 30 +++
 rtl/sdc_dq_rd_capture.sv | 65 ++++++
 rtl/sdc_dq_ctrl.sv | 126 ++++++++++++
 tb/tb_sdc_dq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sdc_dq_pkg.sv
// Shared types and constants for the DQ sequencing stage; data width tracks `SDC_DATA_MSB.
// Tristate encoding matches the pad wrapper: 0 drives the pin, 1 releases it.
`ifndef SDC_DATA_MSB
`define SDC_DATA_MSB 31
`endif

package sdc_dq_pkg;
   localparam int DW = `SDC_DATA_MSB + 1;

   localparam logic DQ_DRIVE = 1'b0;
   localparam logic DQ_HIZ   = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_PRE,
      S_WR_DATA,
      S_WR_POST,
      S_RD_WAIT,
      S_RD_DATA,
      S_RD_TURN
   } state_t;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction
endpackage

// File: rtl/sdc_dq_rd_capture.sv
// Read-side latency counter and capture pipeline; SDC_DQ_RD_IREG_EN adds a pad input register.
// wait_last marks the final CAS wait cycle; cap selects the cycles whose pad data is returned.
module sdc_dq_rd_capture
   import sdc_dq_pkg::*;
#(
   parameter int DW       = 32,
   parameter int WAIT_CYC = 2,
   parameter int CNT_W    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          cap,
   input  logic [DW-1:0] dq_i,
   output logic          wait_last,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid
);

   logic             waiting;
   logic [CNT_W-1:0] lat_cnt;
   logic [DW-1:0]    cap_src;

   assign wait_last = waiting && (lat_cnt == CNT_W'(WAIT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         waiting <= 1'b0;
         lat_cnt <= '0;
      end else if (start) begin
         waiting <= 1'b1;
         lat_cnt <= '0;
      end else if (wait_last) begin
         waiting <= 1'b0;
         lat_cnt <= '0;
      end else if (waiting) begin
         lat_cnt <= lat_cnt + 1'b1;
      end
   end

`ifdef SDC_DQ_RD_IREG_EN
   // The wait is one cycle longer, so this register realigns capture to the same pad cycles.
   logic [DW-1:0] dq_q;

   always_ff @(posedge clk) begin
      if (!rst_n) dq_q <= '0;
      else        dq_q <= dq_i;
   end

   assign cap_src = dq_q;
`else
   assign cap_src = dq_i;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= cap;
         if (cap) rd_data <= cap_src;
      end
   end

endmodule

// File: rtl/sdc_dq_ctrl.sv
// DQ sequencer: fixed-timing write launch and CAS-aligned read capture with bus turnaround.
// SDC_DQ_RD_IREG_EN registers pad input data, stretching the read wait by one cycle.
module sdc_dq_ctrl
   import sdc_dq_pkg::*;
#(
   parameter int DW        = sdc_dq_pkg::DW,
   parameter int BURST_LEN = 4,
   parameter int CAS_LAT   = 2,
   parameter int RD_TURN   = 1
) (
   input  logic          sdc_clk,
   input  logic          sdc_rst_n,
   input  logic          wr_cmd,
   input  logic          rd_cmd,
   output logic          cmd_rdy,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic [DW-1:0] sdc_dq_o,
   output logic [DW-1:0] sdc_dq_t,
   input  logic [DW-1:0] sdc_dq_i,
   output logic [1:0]    err
);

`ifdef SDC_DQ_RD_IREG_EN
   localparam int WAIT_CYC = CAS_LAT + 1;
`else
   localparam int WAIT_CYC = CAS_LAT;
`endif
   localparam int               CNT_W   = cnt_width(BURST_LEN, WAIT_CYC, RD_TURN);
   localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BURST_LEN - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             rd_start, collide, wait_last, drive_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rd_start = 1'b0;
      collide  = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            if (wr_cmd) begin
               state_nx = S_WR_PRE;
               collide  = rd_cmd;
            end else if (rd_cmd) begin
               state_nx = S_RD_WAIT;
               rd_start = 1'b1;
            end
         end
         S_WR_PRE:  state_nx = S_WR_DATA;
         S_WR_DATA: begin
            if (cnt == BL_LAST) begin
               state_nx = S_WR_POST;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_WR_POST: state_nx = S_IDLE;
         S_RD_WAIT: if (wait_last) state_nx = S_RD_DATA;
         S_RD_DATA: begin
            if (cnt == BL_LAST) begin
               state_nx = (RD_TURN == 0) ? S_IDLE : S_RD_TURN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         S_RD_TURN: begin
            if (int'(cnt) + 1 >= RD_TURN) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign drive_nx = (state_nx == S_WR_PRE) || (state_nx == S_WR_DATA) || (state_nx == S_WR_POST);
   assign cmd_rdy  = (state == S_IDLE);
   assign wr_ready = (state == S_WR_DATA);

   // A write beat is consumed every WR_DATA cycle; a missing beat goes out as zero.
   always_ff @(posedge sdc_clk) begin
      if (!sdc_rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         sdc_dq_t <= {DW{DQ_HIZ}};
         sdc_dq_o <= '0;
         err      <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         sdc_dq_t <= drive_nx ? {DW{DQ_DRIVE}} : {DW{DQ_HIZ}};
         sdc_dq_o <= (state == S_WR_DATA && wr_valid) ? wr_data : '0;
         if (state == S_WR_DATA && !wr_valid) err[0] <= 1'b1;
         if (collide) err[1] <= 1'b1;
      end
   end

   sdc_dq_rd_capture #(
      .DW       (DW),
      .WAIT_CYC (WAIT_CYC),
      .CNT_W    (CNT_W)
   ) u_rd_capture (
      .clk       (sdc_clk),
      .rst_n     (sdc_rst_n),
      .start     (rd_start),
      .cap       (state == S_RD_DATA),
      .dq_i      (sdc_dq_i),
      .wait_last (wait_last),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
   );

endmodule

// File: tb/tb_sdc_dq_ctrl.sv
// Randomized bench for sdc_dq_ctrl: a per-cycle expectation timeline is built from burst timing rules.
// Covers writes with missing beats, reads, collisions, ignored busy commands and random resets.
module tb_sdc_dq_ctrl;
   localparam int DW   = 32;
   localparam int BL   = 4;
   localparam int CL   = 2;
   localparam int RT   = 1;
   localparam int NCYC = 4000;
   localparam int NA   = NCYC + 64;
   localparam int INF  = 1 << 30;
`ifdef SDC_DQ_RD_IREG_EN
   localparam int IREG = 1;
`else
   localparam int IREG = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_cmd = 1'b0, rd_cmd = 1'b0, wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0, sdc_dq_i = '0;
   logic          cmd_rdy, wr_ready, rd_valid;
   logic [DW-1:0] rd_data, sdc_dq_o, sdc_dq_t;
   logic [1:0]    err;

   always #5 clk = ~clk;

   sdc_dq_ctrl #(.DW(DW), .BURST_LEN(BL), .CAS_LAT(CL), .RD_TURN(RT)) dut (
      .sdc_clk   (clk),
      .sdc_rst_n (rst_n),
      .wr_cmd    (wr_cmd),
      .rd_cmd    (rd_cmd),
      .cmd_rdy   (cmd_rdy),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .sdc_dq_o  (sdc_dq_o),
      .sdc_dq_t  (sdc_dq_t),
      .sdc_dq_i  (sdc_dq_i),
      .err       (err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Expected behaviour per cycle index (cycle n follows rising edge n).
   logic [DW-1:0] pad [NA];
   logic [DW-1:0] exp_o [NA];
   logic [DW-1:0] exp_rd [NA];
   logic [DW-1:0] wd [NA];
   bit            exp_drv [NA];
   bit            exp_rdy [NA];
   bit            exp_wrdy [NA];
   bit            exp_rv [NA];
   bit            chk_o [NA];
   bit            sched [NA];
   bit            wv [NA];
   bit            rst_chk [NA];

   initial begin
      int  free_at, err0_at, err1_at, c1, r;
      bit  do_rst, wc, rc;

      for (int i = 0; i < NA; i++) begin
         pad[i]      = $urandom;
         exp_o[i]    = '0;
         exp_rd[i]   = '0;
         wd[i]       = '0;
         exp_drv[i]  = 1'b0;
         exp_rdy[i]  = 1'b1;
         exp_wrdy[i] = 1'b0;
         exp_rv[i]   = 1'b0;
         chk_o[i]    = 1'b0;
         sched[i]    = 1'b0;
         wv[i]       = 1'b0;
         rst_chk[i]  = 1'b0;
      end
      rst_chk[0] = 1'b1;
      free_at    = 0;
      err0_at    = INF;
      err1_at    = INF;

      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk);
         #1;
         cyc = n;
         chk("cmd_rdy", 64'(cmd_rdy), 64'(exp_rdy[n]));
         chk("wr_ready", 64'(wr_ready), 64'(exp_wrdy[n]));
         chk("dq_t", 64'(sdc_dq_t), 64'(exp_drv[n] ? {DW{1'b0}} : {DW{1'b1}}));
         chk("rd_valid", 64'(rd_valid), 64'(exp_rv[n]));
         if (exp_rv[n]) chk("rd_data", 64'(rd_data), 64'(exp_rd[n]));
         if (chk_o[n]) chk("dq_o", 64'(sdc_dq_o), 64'(exp_o[n]));
         chk("err", 64'(err), 64'({n >= err1_at, n >= err0_at}));
         if (rst_chk[n]) begin
            chk("rst_rd_data", 64'(rd_data), 64'(0));
            chk("rst_dq_o", 64'(sdc_dq_o), 64'(0));
         end

         do_rst = (n < 3) || ($urandom_range(0, 149) == 0);
         if (n >= free_at) begin
            r  = $urandom_range(0, 9);
            wc = (r <= 2) || (r == 6);
            rc = (r >= 3 && r <= 6);
         end else begin
            wc = ($urandom_range(0, 7) == 0);
            rc = ($urandom_range(0, 7) == 0);
         end

         rst_n    = !do_rst;
         wr_cmd   = wc;
         rd_cmd   = rc;
         sdc_dq_i = pad[n];
         if (sched[n]) begin
            wr_valid = wv[n];
            wr_data  = wd[n];
         end else begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
         end

         c1 = n + 1;
         if (do_rst) begin
            for (int c = n + 1; c <= n + 40; c++) begin
               exp_drv[c]  = 1'b0;
               exp_rdy[c]  = 1'b1;
               exp_wrdy[c] = 1'b0;
               exp_rv[c]   = 1'b0;
               chk_o[c]    = 1'b0;
               sched[c]    = 1'b0;
            end
            rst_chk[c1] = 1'b1;
            free_at     = c1;
            err0_at     = INF;
            err1_at     = INF;
         end else if (n >= free_at && wc) begin
            // Write: preamble, BL data cycles, postamble; beats show up one cycle after consumption.
            for (int c = c1; c <= c1 + 1 + BL; c++) begin
               exp_drv[c] = 1'b1;
               exp_rdy[c] = 1'b0;
               chk_o[c]   = 1'b1;
            end
            exp_o[c1]     = '0;
            exp_o[c1 + 1] = '0;
            for (int j = 0; j < BL; j++) begin
               exp_wrdy[c1 + 1 + j] = 1'b1;
               sched[c1 + 1 + j]    = 1'b1;
               wv[c1 + 1 + j]       = ($urandom_range(0, 9) != 0);
               wd[c1 + 1 + j]       = $urandom;
               exp_o[c1 + 2 + j]    = wv[c1 + 1 + j] ? wd[c1 + 1 + j] : '0;
               if (!wv[c1 + 1 + j] && err0_at > c1 + 2 + j) err0_at = c1 + 2 + j;
            end
            if (rc && err1_at > c1) err1_at = c1;
            free_at = c1 + 2 + BL;
         end else if (n >= free_at && rc) begin
            // Read: pad beats arrive CL cycles after the first busy cycle and return one cycle later.
            for (int c = c1; c < c1 + CL + IREG + BL + RT; c++) exp_rdy[c] = 1'b0;
            for (int k = 0; k < BL; k++) begin
               exp_rv[c1 + CL + 1 + k + IREG] = 1'b1;
               exp_rd[c1 + CL + 1 + k + IREG] = pad[c1 + CL + k];
            end
            free_at = c1 + CL + IREG + BL + RT;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
